// File: rtl/linear_layer_fifo_pkg.sv
// -----------------------------------------------------------------------------
// linear_layer_fifo_pkg
// Shared helpers for the start-token FIFOs of the Linear_Layer_i4xi4 dataflow
// region: the occupancy-counter width and the legality test for the
// DEPTH / ADDR_WIDTH parameter pair.
// -----------------------------------------------------------------------------
package linear_layer_fifo_pkg;

  // Occupancy counter must hold 0..DEPTH, and DEPTH may equal 2**ADDR_WIDTH,
  // so it needs one bit more than the read address.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

  // True when DEPTH fits the read address and the FIFO holds at least a word.
  function automatic bit fifo_params_ok(input int depth, input int addr_width);
    return (depth >= 1) && (addr_width >= 1) && (depth <= (1 << addr_width));
  endfunction

endpackage : linear_layer_fifo_pkg

// File: rtl/start_fifo_srl_storage.sv
// -----------------------------------------------------------------------------
// start_fifo_srl_storage
// Shift-register storage for the start-token FIFO. A write shifts every entry
// up by one and loads din into entry 0; the read port is an asynchronous
// indexed mux over the entries.
//
// Ports:
//   clk   in   rising-edge clock
//   we    in   shift enable (qualified push from the controller)
//   addr  in   read index, ADDR_WIDTH bits
//   din   in   word loaded into entry 0 on a shift
//   dout  out  entry[addr], combinational
// -----------------------------------------------------------------------------
module start_fifo_srl_storage #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end
  end

  // NOTE: storage has no reset on purpose; validity is tracked by the
  // controller's count, so clearing the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Explicit mux keeps the read in range even when DEPTH < 2**ADDR_WIDTH.
  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_WIDTH'(i)) begin
        dout = mem_q[i];
      end
    end
  end

endmodule : start_fifo_srl_storage

// File: rtl/start_fifo_srl_ctrl.sv
// -----------------------------------------------------------------------------
// start_fifo_srl_ctrl
// Control shell of the shift-register FIFO that carries start tokens between a
// *_U0 producer and the PE it launches. Tracks occupancy, decodes full/empty
// from the registered count, drives the SRL shift enable and read address.
// Read side is first-word-fall-through.
//
// Ports:
//   clk                in   rising-edge clock
//   reset_n            in   synchronous active-low reset (clears occupancy)
//   if_write_ce        in   write chip enable
//   if_write           in   write request
//   if_din             in   write data
//   if_full_n          out  high when a word can be accepted
//   if_read_ce         in   read chip enable
//   if_read            in   read request, acknowledges the current head
//   if_dout            out  head word, valid while if_empty_n is high
//   if_empty_n         out  high when if_dout is valid
//   if_num_data_valid  out  current occupancy 0..DEPTH
//   if_fifo_cap        out  constant DEPTH
// -----------------------------------------------------------------------------
module start_fifo_srl_ctrl
  import linear_layer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap
);

  localparam int                  CW      = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0]       DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]       ONE_C   = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE_C = ADDR_WIDTH'(1);

  if (!fifo_params_ok(DEPTH, ADDR_WIDTH)) begin : g_param_check
    $error("start_fifo_srl_ctrl: need 1 <= DEPTH <= 2**ADDR_WIDTH");
  end

  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // Flags come from the register alone, so there is no path from the request
  // inputs to full/empty.
  assign if_empty_n = (count_q != '0);
  assign if_full_n  = (count_q != DEPTH_C);

  assign push = if_write_ce & if_write & if_full_n;
  assign pop  = if_read_ce  & if_read  & if_empty_n;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;  // idle, or shift+discard keeps the head at count-1
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Oldest entry sits at count-1. Using only the low bits is exact: when
  // count == 2**ADDR_WIDTH the low bits are zero and the decrement wraps to
  // the top index.
  always_comb begin
    rd_addr = '0;
    if (if_empty_n) begin
      rd_addr = count_q[ADDR_WIDTH-1:0] - ADDR_ONE_C;
    end
  end

  start_fifo_srl_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_storage (
    .clk  (clk),
    .we   (push),
    .addr (rd_addr),
    .din  (if_din),
    .dout (if_dout)
  );

  assign if_num_data_valid = count_q;
  assign if_fifo_cap       = DEPTH_C;

endmodule : start_fifo_srl_ctrl

// File: tb/tb_start_fifo_srl_ctrl.sv
// -----------------------------------------------------------------------------
// tb_start_fifo_srl_ctrl
// Directed bench for start_fifo_srl_ctrl. One instance with DEPTH=2 feeds a
// scoreboard: the stimulus pushes each word it expects to be accepted, and a
// monitor pops and compares whenever a read handshake is presented. A second
// instance with DEPTH=1 is checked directly.
// -----------------------------------------------------------------------------
module tb_start_fifo_srl_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=2 instance
  logic       rst_n, w_ce, w, r_ce, r;
  logic [7:0] din, dout;
  logic       full_n, empty_n;
  logic [1:0] num, cap;

  // DEPTH=1 instance
  logic       d1_rst_n, d1_w_ce, d1_w, d1_r_ce, d1_r;
  logic [7:0] d1_din, d1_dout;
  logic       d1_full_n, d1_empty_n;
  logic [1:0] d1_num, d1_cap;

  start_fifo_srl_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(2)) dut2 (
    .clk (clk), .reset_n (rst_n),
    .if_write_ce (w_ce), .if_write (w), .if_din (din), .if_full_n (full_n),
    .if_read_ce (r_ce), .if_read (r), .if_dout (dout), .if_empty_n (empty_n),
    .if_num_data_valid (num), .if_fifo_cap (cap)
  );

  start_fifo_srl_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(1)) dut1 (
    .clk (clk), .reset_n (d1_rst_n),
    .if_write_ce (d1_w_ce), .if_write (d1_w), .if_din (d1_din), .if_full_n (d1_full_n),
    .if_read_ce (d1_r_ce), .if_read (d1_r), .if_dout (d1_dout), .if_empty_n (d1_empty_n),
    .if_num_data_valid (d1_num), .if_fifo_cap (d1_cap)
  );

  int         compare_cnt  = 0;
  int         mismatch_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compare_cnt++;
    if (act !== exp) begin
      mismatch_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a read handshake on dut2 must present the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && r_ce && r && empty_n) begin
      if (exp_q.size() == 0) begin
        check("pop_with_nothing_expected", 32'(dout), 32'hDEAD);
      end else begin
        check("scoreboard_dout", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0; w_ce = 1'b0; w = 1'b0; r_ce = 1'b0; r = 1'b0; din = '0;
    d1_rst_n = 1'b0; d1_w_ce = 1'b0; d1_w = 1'b0; d1_r_ce = 1'b0; d1_r = 1'b0; d1_din = '0;

    // Reset, then idle with ignored reads
    step(); step();
    rst_n = 1'b1; d1_rst_n = 1'b1;
    check("rst_empty_n", 32'(empty_n), 0);
    check("rst_full_n",  32'(full_n),  1);
    check("rst_count",   32'(num),     0);
    check("fifo_cap",    32'(cap),     2);
    r_ce = 1'b1; r = 1'b1;
    step(); step();
    r = 1'b0;
    check("read_empty_ignored", 32'(num), 0);

    // Fill, overflow attempt, drain
    w_ce = 1'b1; w = 1'b1;
    din = 8'hA1; exp_q.push_back(8'hA1); step();
    check("fill1_count", 32'(num),  1);
    check("fill1_dout",  32'(dout), 32'hA1);
    din = 8'hB2; exp_q.push_back(8'hB2); step();
    check("fill2_count",  32'(num),    2);
    check("fill2_full_n", 32'(full_n), 0);
    din = 8'hC3; step();
    w = 1'b0;
    check("overflow_ignored", 32'(num), 2);
    check("overflow_head",    32'(dout), 32'hA1);
    r = 1'b1; step(); step(); r = 1'b0;
    check("drain_empty_n", 32'(empty_n), 0);
    check("drain_full_n",  32'(full_n),  1);

    // Simultaneous push and pop at count=1
    w = 1'b1; din = 8'h11; exp_q.push_back(8'h11); step();
    for (int i = 0; i < 8; i++) begin
      w = 1'b1; r = 1'b1;
      din = 8'h22 + 8'(i); exp_q.push_back(8'h22 + 8'(i));
      step();
      check("pp_count", 32'(num),  1);
      check("pp_dout",  32'(dout), 32'(8'h22 + 8'(i)));
    end
    w = 1'b0; step(); r = 1'b0;
    check("pp_drained", 32'(num), 0);

    // Chip-enable gating
    w = 1'b1; din = 8'h33; exp_q.push_back(8'h33); step();
    w_ce = 1'b0; r_ce = 1'b0; w = 1'b1; r = 1'b1; din = 8'h99;
    for (int i = 0; i < 4; i++) begin
      step();
      check("ce_gate_count", 32'(num), 1);
    end
    check("ce_gate_dout", 32'(dout), 32'h33);
    w = 1'b0; r = 1'b0; w_ce = 1'b1; r_ce = 1'b1;

    // Reset mid-operation with push and pop asserted
    w = 1'b1; din = 8'h44; exp_q.push_back(8'h44); step();
    check("pre_reset_count", 32'(num), 2);
    exp_q.delete();
    rst_n = 1'b0; w = 1'b1; r = 1'b1; din = 8'h55;
    step();
    rst_n = 1'b1; w = 1'b0; r = 1'b0;
    check("midrst_count",   32'(num),     0);
    check("midrst_empty_n", 32'(empty_n), 0);
    check("midrst_full_n",  32'(full_n),  1);
    w = 1'b1; din = 8'h5A; exp_q.push_back(8'h5A); step(); w = 1'b0;
    check("post_rst_dout", 32'(dout), 32'h5A);
    r = 1'b1; step(); r = 1'b0;
    check("post_rst_count", 32'(num), 0);

    // DEPTH=1 instance
    check("d1_cap",     32'(d1_cap),     1);
    check("d1_empty_n", 32'(d1_empty_n), 0);
    d1_w_ce = 1'b1; d1_r_ce = 1'b1;
    d1_w = 1'b1; d1_din = 8'h07; step();
    check("d1_full_n", 32'(d1_full_n), 0);
    check("d1_dout",   32'(d1_dout),   32'h07);
    d1_din = 8'h08; d1_r = 1'b1; step();   // push blocked by full, pop proceeds
    d1_w = 1'b0; d1_r = 1'b0;
    check("d1_pp_count",   32'(d1_num),     0);
    check("d1_pp_full_n",  32'(d1_full_n),  1);
    d1_w = 1'b1; d1_din = 8'h09; step(); d1_w = 1'b0;
    check("d1_refill_dout", 32'(d1_dout), 32'h09);
    d1_r = 1'b1; step(); d1_r = 1'b0;
    check("d1_pop_empty_n", 32'(d1_empty_n), 0);
    check("d1_pop_count",   32'(d1_num),     0);

    step();
    check("scoreboard_leftover", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule : tb_start_fifo_srl_ctrl

// File: doc/start_fifo_srl_ctrl.md
Name: start_fifo_srl_ctrl

Overview:
Control shell for a shift-register (SRL) FIFO that carries start tokens and small payloads between producer and consumer PEs in the Linear_Layer_i4xi4 dataflow region.
- Owns occupancy tracking, full/empty flags, the SRL shift-enable and the read address; the storage array sits in a child sub-module.
- Presents the standard dataflow FIFO handshake: first-word-fall-through read, ready/valid-style write/read with chip enables.
- Instantiated once per start channel between a *_U0 producer and the PE it launches.

Parameters:
DATA_WIDTH, 1, payload width in bits.
ADDR_WIDTH, 1, read-address width; DEPTH <= 2**ADDR_WIDTH (elaboration error otherwise).
DEPTH, 2, FIFO capacity in entries; must be >= 1.

Ports:
clk  in  1  rising-edge clock.
reset_n  in  1  synchronous active-low reset.
if_write_ce  in  1  write chip enable.
if_write  in  1  write request.
if_din  in  DATA_WIDTH  write data.
if_full_n  out  1  high when the FIFO can accept a word.
if_read_ce  in  1  read chip enable.
if_read  in  1  read request, acknowledging the current head.
if_dout  out  DATA_WIDTH  head word (first-word-fall-through).
if_empty_n  out  1  high when if_dout is valid.
if_num_data_valid  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
if_fifo_cap  out  ADDR_WIDTH+1  constant DEPTH.

Behaviour:
- Reset (reset_n=0 at a clk edge, synchronous):
  - count <= 0, so if_empty_n=0, if_full_n=1 (if DEPTH>=1) and if_num_data_valid=0 from the next cycle.
  - Storage contents are not cleared.
  - Reset takes priority over push and pop in the same cycle.
  - Reset mid-operation discards all entries.
- Qualified events:
  - push = if_write_ce & if_write & if_full_n.
  - pop = if_read_ce & if_read & if_empty_n.
  - A write while full is ignored: no shift, no count change, no error.
  - A read while empty is ignored.
- Storage: push drives the SRL shift enable, so the new word goes into entry 0 and older entries move up by one. Entry count-1 is always the oldest.
- Occupancy register count (ADDR_WIDTH+1 bits):
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged. The shift plus discard of the old head leaves the next-oldest entry at count-1.
  - Neither: hold.
  - Never wraps; count stays in 0..DEPTH.
- Flags:
  - if_empty_n = (count != 0).
  - if_full_n = (count != DEPTH).
  - Both are decoded from the count register only; no combinational path from if_write or if_read to either flag.
- Read address: addr = count-1 when count>0, else 0, truncated to ADDR_WIDTH bits.
  - if_dout = storage[addr], combinational from registered state.
  - if_dout is don't-care while if_empty_n=0.
- Latency:
  - A word pushed at edge N is visible on if_dout with if_empty_n=1 after edge N (zero added latency).
  - A pop at edge N exposes the next word after edge N.
- Simultaneous push and pop:
  - When full: not allowed, because if_full_n=0 blocks the push.
  - When empty: not allowed, because if_empty_n=0 blocks the pop.
  - Otherwise legal, and throughput is 1 word per cycle.
- Outputs: if_num_data_valid = count. if_fifo_cap is tied to DEPTH.

Decomposition:
- Shared package (linear_layer_fifo_pkg):
  - Function for the count width (ADDR_WIDTH+1).
  - Elaboration-time checks on DEPTH and ADDR_WIDTH.
- One sub-module: start_fifo_srl_storage (DATA_WIDTH, ADDR_WIDTH, DEPTH). Ports clk, we, addr, din, dout; shift on we, asynchronous indexed read.
- The controller contains all state and flag logic; the storage sub-module has no reset.

Test Plan:
- Reset, then idle: reset_n low 2 cycles then high -> if_empty_n=0, if_full_n=1, if_num_data_valid=0; if_read pulses ignored, count stays 0.
- Fill and drain, DEPTH=2, DATA_WIDTH=8:
  - Push 0xA1 then 0xB2 -> if_full_n=0, count=2.
  - Third push 0xC3 is ignored.
  - Reads return 0xA1 then 0xB2, then if_empty_n=0.
- Simultaneous push and pop at count=1 (head 0x11):
  - Push 0x22 with a read in the same cycle -> count stays 1, if_dout=0x22 next cycle.
  - Repeat for 8 cycles with an incrementing pattern -> in-order output, no loss.
- Chip-enable gating: if_write=1 with if_write_ce=0, and if_read=1 with if_read_ce=0 -> no state change over 4 cycles.
- Reset mid-operation: at count=2, assert reset_n=0 together with push and pop -> next cycle count=0, if_empty_n=0, if_full_n=1; the subsequent push of 0x5A reads back 0x5A.
- DEPTH=1, ADDR_WIDTH=1:
  - Push 0x7 -> if_full_n=0, if_dout=0x7.
  - Push and pop in the same cycle is blocked because the FIFO is full.
  - Pop -> empty.
